// File: rtl/kernel_launch_if.sv
// Host/kernel-facing signal bundle of the kernel launch sequencer.
// The master side is the host; the slave side is the sequencer itself.
interface kernel_launch_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             pause;
  logic             exit_cond;
  logic             kernel_en;
  logic             kernel_rst;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [WIDTH-1:0] cycle_count;

  modport master (
    output start, pause, exit_cond,
    input  kernel_en, kernel_rst, busy, done, timeout, cycle_count
  );

  modport slave (
    input  start, pause, exit_cond,
    output kernel_en, kernel_rst, busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/kernel_launch_ctrl.sv
// Run-control sequencer for a CGRA kernel: reset pulse, enabled run until the
// loop-exit branch fires, pipeline drain, then a one-cycle done pulse.
module kernel_launch_ctrl #(
  parameter int WIDTH        = 32,
  parameter int RST_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int MAX_CYCLES   = 0,
  parameter bit EXIT_LEVEL   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  kernel_launch_if.slave bus
);

  localparam int IW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [IW-1:0]    INIT_LAST  = IW'(RST_CYCLES - 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_CYCLES);

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    init_cnt_q, init_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             en;
  logic [WIDTH-1:0] cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      init_cnt_q  <= '0;
      drain_cnt_q <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // rst gates the enable combinationally so the kernel stops in the reset cycle
  assign en      = ((state_q == RUN) || (state_q == DRAIN)) && !bus.pause && !rst;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    drain_cnt_d = drain_cnt_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = INIT;
          init_cnt_d  = '0;
          drain_cnt_d = '0;
          cnt_d       = '0;
          timeout_d   = 1'b0;
        end
      end
      INIT: begin
        if (init_cnt_q == INIT_LAST) state_d = RUN;
        else                         init_cnt_d = init_cnt_q + IW'(1);
      end
      RUN: begin
        if (en) begin
          cnt_d = cnt_inc;
          // exit takes precedence over a timeout landing on the same cycle
          if (bus.exit_cond == EXIT_LEVEL) begin
            state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          end else if ((MAX_CYCLES != 0) && (cnt_inc == MAX_W)) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (en) begin
          cnt_d = cnt_inc;
          if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
          else                           drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.kernel_en   = en;
  assign bus.kernel_rst  = (state_q == INIT);
  assign bus.busy        = (state_q == INIT) || (state_q == RUN) || (state_q == DRAIN);
  assign bus.done        = (state_q == DONE);
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// Four parameterisations driven by one stimulus stream; each has a
// count-down reference model, plus literal pins at known edges.
module tb_kernel_launch_ctrl;

  localparam int NC = 4;
  localparam int CW [NC] = '{32, 32, 32, 4};
  localparam int CR [NC] = '{2, 2, 2, 1};
  localparam int CD [NC] = '{4, 4, 0, 4};
  localparam int CM [NC] = '{0, 10, 0, 0};
  localparam int CE [NC] = '{0, 0, 0, 1};

  logic clk = 1'b0;
  logic rst, start, pause, exit_cond;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   armed = 1'b0;

  logic [NC-1:0] act_en, act_rst, act_busy, act_done, act_to;
  logic [NC-1:0] exp_en, exp_rst, exp_busy, exp_done, exp_to;
  logic [31:0]   act_cnt [NC];
  logic [31:0]   exp_cnt [NC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NC; g++) begin : cfg
    localparam longint MAXV = (longint'(1) << CW[g]) - 1;

    kernel_launch_if #(.WIDTH(CW[g])) bus ();

    kernel_launch_ctrl #(
      .WIDTH(CW[g]), .RST_CYCLES(CR[g]), .DRAIN_CYCLES(CD[g]),
      .MAX_CYCLES(CM[g]), .EXIT_LEVEL(1'(CE[g]))
    ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
    );

    // bench exit_cond=0 means "exit" for every config
    assign bus.start     = start;
    assign bus.pause     = pause;
    assign bus.exit_cond = exit_cond ^ 1'(CE[g]);

    assign act_en[g]   = bus.kernel_en;
    assign act_rst[g]  = bus.kernel_rst;
    assign act_busy[g] = bus.busy;
    assign act_done[g] = bus.done;
    assign act_to[g]   = bus.timeout;
    assign act_cnt[g]  = 32'(bus.cycle_count);

    int     init_left  = 0;
    int     drain_left = 0;
    bit     running    = 1'b0;
    bit     done_m     = 1'b0;
    bit     to_m       = 1'b0;
    longint cnt        = 0;

    function automatic longint clip(longint v);
      return (v > MAXV) ? MAXV : v;
    endfunction

    assign exp_en[g]   = (running || drain_left > 0) && !pause && !rst;
    assign exp_rst[g]  = (init_left > 0);
    assign exp_busy[g] = (init_left > 0) || running || (drain_left > 0);
    assign exp_done[g] = done_m;
    assign exp_to[g]   = to_m;
    assign exp_cnt[g]  = 32'(clip(cnt));

    always @(posedge clk) begin
      bit en;
      en = (running || drain_left > 0) && !pause;
      if (rst) begin
        init_left = 0; drain_left = 0; running = 0; done_m = 0; to_m = 0; cnt = 0;
      end else if (done_m) begin
        done_m = 0;
      end else if (init_left > 0) begin
        init_left--;
        running = (init_left == 0);
      end else if (running) begin
        if (en) begin
          cnt++;
          if (bus.exit_cond == 1'(CE[g])) begin
            running = 0;
            if (CD[g] == 0) done_m = 1;
            else            drain_left = CD[g];
          end else if (CM[g] != 0 && clip(cnt) == longint'(CM[g])) begin
            running = 0; done_m = 1; to_m = 1;
          end
        end
      end else if (drain_left > 0) begin
        if (en) begin
          cnt++;
          drain_left--;
          done_m = (drain_left == 0);
        end
      end else if (start) begin
        init_left = CR[g]; cnt = 0; to_m = 0;
      end
    end
  end

  task automatic chk(string nm, int g, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cfg%0d got %0d want %0d at edge %0d", nm, g, a, e, cyc + 1);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int g = 0; g < NC; g++) begin
        chk("kernel_en",   g, 32'(act_en[g]),   32'(exp_en[g]));
        chk("kernel_rst",  g, 32'(act_rst[g]),  32'(exp_rst[g]));
        chk("busy",        g, 32'(act_busy[g]), 32'(exp_busy[g]));
        chk("done",        g, 32'(act_done[g]), 32'(exp_done[g]));
        chk("timeout",     g, 32'(act_to[g]),   32'(exp_to[g]));
        chk("cycle_count", g, act_cnt[g],       exp_cnt[g]);
      end
    end
  end

  // e is the edge at which the inputs being set are sampled
  task automatic drive(int e);
    bit rnd;
    rnd       = (e >= 230);
    rst       = (e == 128) || (rnd && $urandom_range(99) == 0);
    start     = (e == 10) || (e == 50) || (e >= 100 && e <= 117) || (e == 200) ||
                (rnd && $urandom_range(7) == 0);
    pause     = (e >= 58 && e <= 62) || (e >= 79 && e <= 81) ||
                (rnd && $urandom_range(3) == 0);
    exit_cond = !((e == 32) || (e == 60) || (e == 77) || (e == 110) || (e == 125) ||
                  (e == 212) || (rnd && $urandom_range(9) == 0));
  endtask

  // literal expectations at edges worked out by hand from the timing rules
  task automatic pins(int e);
    if (e == 2) begin
      chk("pin_rst_busy", 0, 32'(act_busy[0]), 0);
      chk("pin_rst_en",   0, 32'(act_en[0]),   0);
      chk("pin_rst_krst", 0, 32'(act_rst[0]),  0);
      chk("pin_rst_done", 0, 32'(act_done[0]), 0);
      chk("pin_rst_to",   0, 32'(act_to[0]),   0);
      chk("pin_rst_cnt",  0, act_cnt[0],       0);
    end
    if (e == 11 || e == 12) chk("pin_krst_hi", 0, 32'(act_rst[0]), 1);
    if (e == 13) chk("pin_krst_lo", 0, 32'(act_rst[0]), 0);
    if (e == 12) chk("pin_en_lo12", 0, 32'(act_en[0]), 0);
    if (e == 13 || e == 36) chk("pin_en_hi", 0, 32'(act_en[0]), 1);
    if (e == 37) begin
      chk("pin_en_lo37", 0, 32'(act_en[0]), 0);
      chk("pin_done37",  0, 32'(act_done[0]), 1);
      chk("pin_cnt37",   0, act_cnt[0], 24);
      chk("pin_done37",  2, 32'(act_done[2]), 0);
      chk("pin_sat_done", 3, 32'(act_done[3]), 1);
      chk("pin_sat_cnt",  3, act_cnt[3], 15);
    end
    if (e == 38) chk("pin_busy38", 0, 32'(act_busy[0]), 0);
    if (e == 23) begin
      chk("pin_to_done", 1, 32'(act_done[1]), 1);
      chk("pin_to_flag", 1, 32'(act_to[1]),   1);
      chk("pin_to_cnt",  1, act_cnt[1],       10);
    end
    if (e == 33) begin
      chk("pin_nodrain_done", 2, 32'(act_done[2]), 1);
      chk("pin_nodrain_cnt",  2, act_cnt[2],       20);
    end
    if (e == 60 || e == 80) chk("pin_paused_en", 0, 32'(act_en[0]), 0);
    if (e == 84) chk("pin_done84", 0, 32'(act_done[0]), 0);
    if (e == 85) begin
      chk("pin_done85", 0, 32'(act_done[0]), 1);
      chk("pin_cnt85",  0, act_cnt[0],       24);
    end
    if (e == 116) chk("pin_idle116", 0, 32'(act_busy[0]), 0);
    if (e == 117) chk("pin_reinit",  0, 32'(act_rst[0]),  1);
    if (e == 128) chk("pin_rst_en_drop", 0, 32'(act_en[0]), 0);
    if (e == 129) begin
      chk("pin_midrst_busy", 0, 32'(act_busy[0]), 0);
      chk("pin_midrst_cnt",  0, act_cnt[0],       0);
    end
    if (e == 129 || e == 130) chk("pin_midrst_done", 0, 32'(act_done[0]), 0);
    if (e == 217) begin
      chk("pin_exitwins_done", 1, 32'(act_done[1]), 1);
      chk("pin_exitwins_to",   1, 32'(act_to[1]),   0);
      chk("pin_exitwins_cnt",  1, act_cnt[1],       14);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; exit_cond = 1'b1;
    @(posedge clk); #1;
    armed = 1'b1;
    while (cyc < 700) begin
      drive(cyc + 1);
      @(negedge clk);
      pins(cyc + 1);
      @(posedge clk); #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
